iddmm_seq_ctrl: RTL and testbench

IDDMM_SEQ_CTRL -- requirements
Module: iddmm_seq_ctrl

---
 rtl/iddmm_seq_ctrl.sv | 159 +++++++++++++++
 tb/tb_iddmm_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/iddmm_seq_ctrl.sv
// IDDMM sequencer: task accept, MAC issue loops, pipeline drain,
// result readout and accumulator clear for one Montgomery task.
module iddmm_seq_ctrl #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N),
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_req,
  input  logic [ADDR_W:0]   n_words,
  input  logic              ld_done,
  input  logic              abort,
  input  logic              res_ready,
  output logic              task_grant,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr_i,
  output logic [ADDR_W:0]   rd_addr_j,
  output logic              mac_en,
  output logic              mac_last_j,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_addr,
  output logic              res_last,
  output logic              clr_en,
  output logic [ADDR_W:0]   clr_addr,
  output logic              task_end
);

  localparam int AW1 = ADDR_W + 1;

  if (K < 1 || LAT < 1 || LAT > 15) begin : g_bad_param
    $error("iddmm_seq_ctrl: K must be >0 and LAT in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE, WAIT_LD, MAC, DRAIN, OUTPUT, CLEAR
  } state_t;

  state_t            state, s_n;
  logic [ADDR_W:0]   nw, nw_n;
  logic [ADDR_W-1:0] i_n, ra_n;
  logic [ADDR_W:0]   j_n, ca_n;
  logic [3:0]        dcnt, d_n;
  logic              grant_n, end_n;
  logic              mac_n, mlj_n, rv_n, last_n;
  logic              clr_n, busy_n;
  logic              j_wrap, i_last, r_last;

  assign j_wrap = (rd_addr_j == nw);
  assign i_last = ({1'b0, rd_addr_i} == nw - 1'b1);
  assign r_last = ({1'b0, res_addr} == nw - 1'b1);

  // Next state, loop counters and next output values.
  always_comb begin
    s_n     = state;
    nw_n    = nw;
    i_n     = '0;
    j_n     = '0;
    ra_n    = '0;
    ca_n    = '0;
    d_n     = '0;
    grant_n = 1'b0;
    end_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (task_req) begin
          s_n     = WAIT_LD;
          grant_n = 1'b1;
          if (n_words == '0 || n_words > AW1'(N))
            nw_n = AW1'(N);
          else
            nw_n = n_words;
        end
      end
      WAIT_LD: begin
        if (abort)        s_n = CLEAR;
        else if (ld_done) s_n = MAC;
      end
      MAC: begin
        if (abort) begin
          s_n = CLEAR;
        end else if (j_wrap && i_last) begin
          s_n = DRAIN;
          d_n = 4'(LAT - 1);
        end else if (j_wrap) begin
          i_n = rd_addr_i + 1'b1;
        end else begin
          i_n = rd_addr_i;
          j_n = rd_addr_j + 1'b1;
        end
      end
      DRAIN: begin
        if (abort)             s_n = CLEAR;
        else if (dcnt == 4'd0) s_n = OUTPUT;
        else                   d_n = dcnt - 1'b1;
      end
      OUTPUT: begin
        if (abort)               s_n  = CLEAR;
        else if (!res_ready)     ra_n = res_addr;
        else if (r_last)         s_n  = CLEAR;
        else                     ra_n = res_addr + 1'b1;
      end
      CLEAR: begin
        if (clr_addr == nw) begin
          s_n   = IDLE;
          end_n = 1'b1;
        end else begin
          ca_n = clr_addr + 1'b1;
        end
      end
      default: s_n = IDLE;
    endcase
    mac_n  = (s_n == MAC);
    rv_n   = (s_n == OUTPUT);
    clr_n  = (s_n == CLEAR);
    busy_n = (s_n != IDLE);
    mlj_n  = mac_n && (j_n == nw_n);
    last_n = rv_n && ({1'b0, ra_n} == nw_n - 1'b1);
  end

  // State, counters and every output are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nw         <= '0;
      dcnt       <= '0;
      rd_addr_i  <= '0;
      rd_addr_j  <= '0;
      res_addr   <= '0;
      clr_addr   <= '0;
      task_grant <= 1'b0;
      task_end   <= 1'b0;
      busy       <= 1'b0;
      mac_en     <= 1'b0;
      mac_last_j <= 1'b0;
      res_valid  <= 1'b0;
      res_last   <= 1'b0;
      clr_en     <= 1'b0;
    end else begin
      state      <= s_n;
      nw         <= nw_n;
      dcnt       <= d_n;
      rd_addr_i  <= i_n;
      rd_addr_j  <= j_n;
      res_addr   <= ra_n;
      clr_addr   <= ca_n;
      task_grant <= grant_n;
      task_end   <= end_n;
      busy       <= busy_n;
      mac_en     <= mac_n;
      mac_last_j <= mlj_n;
      res_valid  <= rv_n;
      res_last   <= last_n;
      clr_en     <= clr_n;
    end
  end

endmodule

// File: tb/tb_iddmm_seq_ctrl.sv
// Bench for iddmm_seq_ctrl: phase/step reference model checked
// every cycle, directed scenarios with literal counts, random traffic.
module tb_iddmm_seq_ctrl;

  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          task_req = 1'b0;
  logic [AW:0]   n_words = '0;
  logic          ld_done = 1'b0;
  logic          abort = 1'b0;
  logic          res_ready = 1'b0;
  logic          task_grant, busy, mac_en, mac_last_j;
  logic          res_valid, res_last, clr_en, task_end;
  logic [AW-1:0] rd_addr_i, res_addr;
  logic [AW:0]   rd_addr_j, clr_addr;

  iddmm_seq_ctrl #(.K(128), .N(N), .ADDR_W(AW), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .task_req(task_req),
    .n_words(n_words), .ld_done(ld_done), .abort(abort),
    .res_ready(res_ready), .task_grant(task_grant), .busy(busy),
    .rd_addr_i(rd_addr_i), .rd_addr_j(rd_addr_j), .mac_en(mac_en),
    .mac_last_j(mac_last_j), .res_valid(res_valid),
    .res_addr(res_addr), .res_last(res_last), .clr_en(clr_en),
    .clr_addr(clr_addr), .task_end(task_end)
  );

  always #5 clk = ~clk;

  logic [17:0] ov;
  assign ov = {task_grant, busy, rd_addr_i, rd_addr_j, mac_en,
               mac_last_j, res_valid, res_addr, res_last, clr_en,
               clr_addr, task_end};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // Reference model: phase 0 idle, 1 wait, 2 mac, 3 drain,
  // 4 output, 5 clear; mk is the step index inside the phase.
  int mph, mk, mnw;
  logic mgrant, mend;

  function automatic int eff_nw(input int v);
    return (v == 0 || v > N) ? N : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mph <= 0; mk <= 0; mnw <= 0; mgrant <= 0; mend <= 0;
    end else begin
      mgrant <= 0;
      mend   <= 0;
      case (mph)
        0: if (task_req) begin
          mnw <= eff_nw(int'(n_words)); mph <= 1; mgrant <= 1;
        end
        1: if (abort) begin mph <= 5; mk <= 0; end
           else if (ld_done) begin mph <= 2; mk <= 0; end
        2: if (abort) begin mph <= 5; mk <= 0; end
           else if (mk == mnw * (mnw + 1) - 1) begin mph <= 3; mk <= 0; end
           else mk <= mk + 1;
        3: if (abort) begin mph <= 5; mk <= 0; end
           else if (mk == LAT - 1) begin mph <= 4; mk <= 0; end
           else mk <= mk + 1;
        4: if (abort) begin mph <= 5; mk <= 0; end
           else if (res_ready) begin
             if (mk == mnw - 1) begin mph <= 5; mk <= 0; end
             else mk <= mk + 1;
           end
        5: if (mk == mnw) begin mph <= 0; mk <= 0; mend <= 1; end
           else mk <= mk + 1;
        default: mph <= 0;
      endcase
    end
  end

  // Per-task statistics, cleared on each grant.
  int st_mac, st_mlj, st_drain, st_rv, st_acc, st_clr;
  int st_clrmax, st_lastaddr, st_te, te_total, g_total;
  bit seen_mac, seen_res;

  // Every-cycle compare against the model, then statistics.
  always @(negedge clk) begin
    int ei, ej, er, ec;
    logic [17:0] ev;
    ei = (mph == 2) ? mk / (mnw + 1) : 0;
    ej = (mph == 2) ? mk % (mnw + 1) : 0;
    er = (mph == 4) ? mk : 0;
    ec = (mph == 5) ? mk : 0;
    ev = {mgrant, 1'(mph != 0), 2'(ei), 3'(ej), 1'(mph == 2),
          1'(mph == 2 && ej == mnw), 1'(mph == 4), 2'(er),
          1'(mph == 4 && er == mnw - 1), 1'(mph == 5), 3'(ec), mend};
    checks++;
    if (ov !== ev) begin
      failures++;
      $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, ov, ev);
    end
    if (task_grant) begin
      st_mac = 0; st_mlj = 0; st_drain = 0; st_rv = 0; st_acc = 0;
      st_clr = 0; st_clrmax = -1; st_lastaddr = -1; st_te = 0;
      seen_mac = 0; seen_res = 0; g_total++;
    end
    if (mac_en) begin
      st_mac++; seen_mac = 1;
      if (mac_last_j) st_mlj++;
    end
    if (busy && seen_mac && !seen_res && !mac_en && !res_valid && !clr_en)
      st_drain++;
    if (res_valid) begin
      seen_res = 1; st_rv++;
      if (res_ready) begin
        st_acc++;
        if (res_last) st_lastaddr = int'(res_addr);
      end
    end
    if (clr_en) begin st_clr++; st_clrmax = int'(clr_addr); end
    if (task_end) begin st_te++; te_total++; end
  end

  task automatic run_task(input int nwin, input bit tog, input int ab_at);
    bit ok = 0;
    bit tg = 1;
    int cyc = 0;
    @(posedge clk); #1;
    task_req = 1; n_words = 3'(nwin); res_ready = 1;
    @(posedge clk); #1; task_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1; ld_done = 1;
    while (cyc < 400 && !ok) begin
      abort = (ab_at > 0 && mac_en && st_mac == ab_at - 1);
      if (tog && res_valid) begin res_ready = tg; tg = ~tg; end
      if (task_end) ok = 1;
      else begin @(posedge clk); #1; cyc++; end
    end
    abort = 0; ld_done = 0; res_ready = 1;
    chk("task_timeout", int'(ok), 1);
    @(negedge clk); #1;
  endtask

  initial begin
    int te0;
    bit hit;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'(ov), 0);
    @(posedge clk); #1; rst_n = 1;

    run_task(4, 0, 0);
    chk("t1_mac_cycles", st_mac, 20);
    chk("t1_last_j", st_mlj, 4);
    chk("t1_drain", st_drain, 3);
    chk("t1_results", st_acc, 4);
    chk("t1_res_last_addr", st_lastaddr, 3);
    chk("t1_clears", st_clr, 5);
    chk("t1_clr_max", st_clrmax, 4);
    chk("t1_task_end", st_te, 1);

    run_task(0, 0, 0);
    chk("nw0_mac_cycles", st_mac, 20);
    run_task(7, 0, 0);
    chk("nw7_mac_cycles", st_mac, 20);

    run_task(2, 0, 0);
    chk("nw2_mac_cycles", st_mac, 6);
    chk("nw2_results", st_acc, 2);
    chk("nw2_clears", st_clr, 3);

    run_task(4, 1, 0);
    chk("tog_results", st_acc, 4);
    chk("tog_valid_cycles", st_rv, 7);

    run_task(4, 0, 7);
    chk("abort_mac_cycles", st_mac, 7);
    chk("abort_clears", st_clr, 5);
    chk("abort_task_end", st_te, 1);
    chk("abort_busy_after", int'(busy), 0);

    @(posedge clk); #1; task_req = 1; n_words = 3;
    @(posedge clk); #1; task_req = 0; ld_done = 1;
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(posedge clk); #1;
      if (res_valid) hit = 1;
    end
    chk("rst_reach_output", int'(hit), 1);
    te0 = te_total;
    rst_n = 0; #1;
    chk("rst_mid_output", int'(ov), 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst_n = 1; ld_done = 0;
    repeat (4) @(posedge clk);
    chk("rst_no_task_end", te_total, te0);
    te0 = g_total;
    run_task(1, 0, 0);
    chk("rst_regrant", g_total, te0 + 1);
    chk("rst_new_mac", st_mac, 2);

    repeat (3000) begin
      @(posedge clk); #1;
      task_req  = ($urandom % 6 == 0);
      n_words   = 3'($urandom % 8);
      ld_done   = ($urandom % 3 == 0);
      res_ready = 1'($urandom % 2);
      abort     = ($urandom % 40 == 0);
    end
    @(posedge clk); #1;
    task_req = 0; abort = 0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
